rr_chan_mux: RTL and testbench

- Parametrised N-channel successor to the team's 2:1 select mux.
- Arbitrates N valid/ready input channels onto one registered output channel.
- Arbitration is fixed-priority or round-robin, chosen at run time.
- Sits between producer blocks and a shared downstream consumer; one beat per accepted transfer, one-cycle latency.

---
 rtl/rr_chan_mux_pkg.sv | 27 ++
 rtl/rr_chan_mux_arb.sv | 48 ++++
 rtl/rr_chan_mux.sv | 128 ++++++++++++
 tb/tb_rr_chan_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_chan_mux_pkg.sv
// rr_chan_mux_pkg
// Shared types and helpers for the N-channel round-robin / fixed-priority
// channel mux.
//   lock_state_e  : packet-lock FSM states (used only with RR_CHAN_MUX_PKT_LOCK_EN)
//   DEF_NCH/DEF_W : default channel count and data width
//   rr_wrap       : folds an index in [0, 2*nch) back into [0, nch)
//   next_rr_idx   : round-robin successor of a granted index
package rr_chan_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 8;

    // Callers only ever pass values below 2*nch, so one subtraction is enough.
    function automatic int rr_wrap(input int i, input int nch);
        return (i >= nch) ? (i - nch) : i;
    endfunction

    function automatic int next_rr_idx(input int g, input int nch);
        return rr_wrap(g + 1, nch);
    endfunction

endpackage

// File: rtl/rr_chan_mux_arb.sv
// rr_chan_mux_arb
// Purely combinational winner selection.
//   mode_rr     in  : 0 = lowest requesting index wins, 1 = search from ptr with wrap
//   req         in  : per-channel request vector
//   ptr         in  : round-robin start index
//   grant_idx   out : winning channel (0 when nothing requests)
//   grant_valid out : at least one channel requests
module rr_chan_mux_arb
    import rr_chan_mux_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int IDXW = $clog2(NCH)
) (
    input  logic            mode_rr,
    input  logic [NCH-1:0]  req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [IDXW-1:0] cand;

    // Both searches walk from the lowest-priority candidate to the highest so
    // that the last hit written is the winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (mode_rr) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                cand = IDXW'(rr_wrap(int'(ptr) + k, NCH));
                if (req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                cand = IDXW'(i);
                if (req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/rr_chan_mux.sv
// rr_chan_mux
// Arbitrates NCH valid/ready input channels onto one registered output
// channel with one-cycle latency and full 1 beat/cycle throughput.
//   clk, rst_n   : clock, asynchronous active-low reset
//   mode_rr      : 0 = fixed priority, 1 = round-robin
//   in_valid     : per-channel valid
//   in_data      : channel i at bits [i*W +: W]
//   in_last      : end-of-packet marker (packet-lock build only)
//   in_ready     : one-hot (or zero) ready to the winning channel
//   out_valid    : output register holds a beat
//   out_data     : registered data
//   out_idx      : source channel of the output beat
//   out_ready    : downstream accepts
// Optional feature macro: RR_CHAN_MUX_PKT_LOCK_EN. When defined, a channel
// that starts a packet keeps the grant until its in_last beat, and the
// round-robin pointer advances only on that last beat.
module rr_chan_mux
    import rr_chan_mux_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int W    = DEF_W,
    parameter int IDXW = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_rr,
    input  logic [NCH-1:0]     in_valid,
    input  logic [NCH*W-1:0]   in_data,
    input  logic [NCH-1:0]     in_last,
    output logic [NCH-1:0]     in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [IDXW-1:0]    out_idx,
    input  logic               out_ready
);

    logic            load;
    logic            xfer;
    logic            eff_mode;
    logic            pkt_end;
    logic [NCH-1:0]  arb_req;
    logic [IDXW-1:0] grant_idx;
    logic            grant_valid;
    logic [IDXW-1:0] ptr_q;

    // The output register may take a new beat when empty or when the
    // current beat leaves this cycle.
    assign load     = !out_valid || out_ready;
    assign xfer     = grant_valid && load;
    assign in_ready = xfer ? (NCH'(1) << grant_idx) : '0;

`ifdef RR_CHAN_MUX_PKT_LOCK_EN
    lock_state_e     state_q;
    lock_state_e     state_d;
    logic [IDXW-1:0] lock_idx_q;
    logic            lock_mode_q;

    // While a packet is open only its owner may request, and the mode seen
    // by the arbiter and pointer is the one captured at packet start.
    assign pkt_end  = in_last[grant_idx];
    assign eff_mode = (state_q == LOCKED) ? lock_mode_q : mode_rr;
    assign arb_req  = (state_q == LOCKED) ? (in_valid & (NCH'(1) << lock_idx_q)) : in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_idx_q  <= '0;
            lock_mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer && state_q == IDLE) begin
                lock_idx_q  <= grant_idx;
                lock_mode_q <= mode_rr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = pkt_end ? IDLE : LOCKED;
        end
    end
`else
    logic unused_in_last;

    assign unused_in_last = ^in_last;
    assign pkt_end        = 1'b1;
    assign eff_mode       = mode_rr;
    assign arb_req        = in_valid;
`endif

    rr_chan_mux_arb #(
        .NCH  (NCH),
        .IDXW (IDXW)
    ) u_arb (
        .mode_rr     (eff_mode),
        .req         (arb_req),
        .ptr         (ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Fixed-priority grants leave the pointer alone so round-robin resumes
    // where it stopped after a mode switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (xfer && eff_mode && pkt_end) begin
            ptr_q <= IDXW'(next_rr_idx(int'(grant_idx), NCH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= in_data[grant_idx*W +: W];
                out_idx  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_chan_mux.sv
// tb_rr_chan_mux
// Directed bench for rr_chan_mux (NCH=4, W=8). A vector table covers fixed
// priority, round-robin rotation, wrap and idle; hand sequences cover
// backpressure, async reset and (with RR_CHAN_MUX_PKT_LOCK_EN) packet lock.
module tb_rr_chan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_rr;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    // Channel payloads stay fixed so held-data checks are trivially legal.
    logic [31:0] chan_words = 32'h43A5_2110;

    typedef struct {
        logic       m_rr;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[16];

    rr_chan_mux #(
        .NCH (4),
        .W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_rr   (mode_rr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chan_data(input logic [1:0] i);
        return chan_words[i*8 +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic m, input logic [3:0] v, input logic [3:0] l, input logic r);
        mode_rr   = m;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        #1;
    endtask

    // Checks the combinational ready, clocks one edge, then checks the output register.
    task automatic check_output(input string tag, input logic [3:0] exp_rdy,
                                input logic exp_ov, input logic [1:0] exp_idx);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check({tag, "_out_idx"}, 32'(out_idx), 32'(exp_idx));
            check({tag, "_out_data"}, 32'(out_data), 32'(chan_data(exp_idx)));
        end
    endtask

    // Protocol monitor: a channel left waiting must present the same data next cycle.
    logic [3:0]  pend;
    logic [31:0] pend_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && in_valid[i]) begin
                    check($sformatf("hold_ch%0d", i), 32'(in_data[i*8 +: 8]), 32'(pend_data[i*8 +: 8]));
                end
            end
            pend = in_valid & ~in_ready;
        end
        pend_data = in_data;
    end

    initial begin
        // Pointer history in comments is the expected rr pointer after each beat.
        vecs[0]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[1]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 2
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2}; // ptr 3
        vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3}; // ptr 0
        vecs[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1
        vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 2
        vecs[9]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2}; // ptr 3
        vecs[10] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0}; // ptr 3
        vecs[11] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3}; // ptr 0
        vecs[12] = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1
        vecs[13] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1}; // ptr 1
        vecs[14] = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2}; // ptr 3
        vecs[15] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 1

        rst_n     = 1'b0;
        mode_rr   = 1'b0;
        in_valid  = 4'b0000;
        in_last   = 4'hF;
        in_data   = chan_words;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].m_rr, vecs[i].valid, 4'hF, vecs[i].ready);
            check_output($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_idx);
        end

        $display("[TB] backpressure");
        apply_stimulus(1'b0, 4'b0100, 4'hF, 1'b1);
        check_output("bp_load", 4'b0100, 1'b1, 2'd2);
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, 4'b1111, 4'hF, 1'b0);
            check_output($sformatf("bp_hold%0d", c), 4'b0000, 1'b1, 2'd2);
        end
        apply_stimulus(1'b0, 4'b1111, 4'hF, 1'b1);
        check_output("bp_release", 4'b0001, 1'b1, 2'd0);

        $display("[TB] async reset");
        apply_stimulus(1'b1, 4'b1111, 4'hF, 1'b1);
        check_output("rs_pre", 4'b0010, 1'b1, 2'd1); // ptr 2
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_out_idx", 32'(out_idx), 32'd0);
        check("rs_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 4'b0110, 4'hF, 1'b1);
        check_output("rs_post", 4'b0010, 1'b1, 2'd1); // ptr 2

`ifdef RR_CHAN_MUX_PKT_LOCK_EN
        $display("[TB] packet lock");
        apply_stimulus(1'b1, 4'b0001, 4'hF, 1'b1);
        check_output("lk_pre", 4'b0001, 1'b1, 2'd0);  // ptr 1
        apply_stimulus(1'b1, 4'b0011, 4'b0000, 1'b1);
        check_output("lk_b1", 4'b0010, 1'b1, 2'd1);
        apply_stimulus(1'b0, 4'b0011, 4'b0000, 1'b1);
        check_output("lk_b2", 4'b0010, 1'b1, 2'd1);
        apply_stimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        check_output("lk_gap", 4'b0000, 1'b0, 2'd0);
        apply_stimulus(1'b0, 4'b0011, 4'b0010, 1'b1);
        check_output("lk_b3", 4'b0010, 1'b1, 2'd1);   // ptr 2 via captured rr mode
        apply_stimulus(1'b1, 4'b0101, 4'hF, 1'b1);
        check_output("lk_ptr", 4'b0100, 1'b1, 2'd2);  // ptr 3
        apply_stimulus(1'b1, 4'b0001, 4'hF, 1'b1);
        check_output("lk_ch0", 4'b0001, 1'b1, 2'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
